demultiplexer_1to4_buffered: RTL and testbench

DEMULTIPLEXER_1TO4_BUFFERED -- requirements
Module: demultiplexer_1to4_buffered

---
 rtl/demux_pkg.sv | 22 ++
 rtl/demux_lane.sv | 46 ++++
 rtl/demultiplexer_1to4_buffered.sv | 70 +++++++
 tb/tb_demultiplexer_1to4_buffered.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants, types and helpers for the buffered 1-to-4 demultiplexer.
package demux_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0]     lane_sel_t;
  typedef logic [NUM_LANES-1:0] lane_vec_t;

  // Round-robin advance; the pointer is exactly SEL_W bits wide, so 3 wraps to 0.
  function automatic lane_sel_t next_rr(input lane_sel_t ptr);
    return ptr + lane_sel_t'(1);
  endfunction

  function automatic lane_vec_t lane_onehot(input lane_sel_t sel);
    lane_vec_t vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/demux_lane.sv
// One-entry output buffer: a data register plus a full flag, loaded from the
// demux input and drained by the downstream handshake.
module demux_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A load wins over a drain, covering the same-edge drain-and-refill case.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    full_d = full_q;
    data_d = data_q;
    if (load) begin
      full_d = 1'b1;
      data_d = load_data;
    end else if (drain) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      // NOTE: the data register is reset too, because out_data must read zero while reset is held.
      data_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign data = data_q;

endmodule

// File: rtl/demultiplexer_1to4_buffered.sv
// Routes one input stream to four independently buffered output lanes, chosen
// either by in_select or by an internal round-robin pointer.
module demultiplexer_1to4_buffered
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_select,
  input  logic                     in_auto,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output logic [NUM_LANES-1:0]     out_valid,
  input  logic [NUM_LANES-1:0]     out_ready,
  output logic [SEL_W-1:0]         rr_ptr
);

  lane_sel_t  rr_ptr_q, rr_ptr_d;
  lane_sel_t  dest;
  lane_vec_t  full_w;
  lane_vec_t  load_vec;
  lane_vec_t  drain_vec;
  logic       accept;
  logic [WIDTH-1:0] lane_data [NUM_LANES];

  assign dest = in_auto ? rr_ptr_q : in_select;

  // Gated by rst_n so upstream sees no readiness while reset is held.
  assign in_ready  = rst_n & (~full_w[dest] | out_ready[dest]);
  assign accept    = in_valid & in_ready;
  assign load_vec  = accept ? lane_onehot(dest) : '0;
  assign drain_vec = full_w & out_ready;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && in_auto) begin
      rr_ptr_d = next_rr(rr_ptr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    demux_lane #(
      .WIDTH(WIDTH)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_vec[k]),
      .load_data(in_data),
      .drain    (drain_vec[k]),
      .full     (full_w[k]),
      .data     (lane_data[k])
    );
    assign out_data[k*WIDTH +: WIDTH] = lane_data[k];
  end

  assign out_valid = full_w;
  assign rr_ptr    = rr_ptr_q;

endmodule

// File: tb/tb_demultiplexer_1to4_buffered.sv
// Directed self-checking bench for demultiplexer_1to4_buffered (WIDTH=8).
module tb_demultiplexer_1to4_buffered;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_select;
  logic             in_auto;
  logic             in_valid;
  logic             in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [1:0]       rr_ptr;

  int checks;
  int errors;

  demultiplexer_1to4_buffered #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_select(in_select),
    .in_auto  (in_auto),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rr_ptr   (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [WIDTH-1:0] lane(input int k);
    return out_data[k*WIDTH +: WIDTH];
  endfunction

  task automatic drive(input logic v, input logic a, input logic [1:0] s, input logic [WIDTH-1:0] d);
    in_valid  = v;
    in_auto   = a;
    in_select = s;
    in_data   = d;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    out_ready = 4'b1111;
    drive(1'b0, 1'b0, 2'd0, 8'h00);

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  out_data,       32'h0);
    check("rst_rr_ptr",    32'(rr_ptr),    32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h0);

    // Manual routing: A0..A3 to lanes 0..3, each out_valid a one-cycle pulse
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 2'd0, 8'hA0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("man_valid", 32'(out_valid), 32'(4'b0001 << i));
      check("man_data",  32'(lane(i)),   32'(8'hA0 + i));
      if (i < 3) drive(1'b1, 1'b0, 2'(i + 1), 8'(8'hA1 + i));
      else       drive(1'b0, 1'b0, 2'd3, 8'h00);
    end
    @(negedge clk);
    check("man_drained",   32'(out_valid), 32'h0);
    check("man_data_hold", 32'(lane(3)),   32'hA3);
    check("man_rr_hold",   32'(rr_ptr),    32'h0);

    // Backpressure on lane 2 with drain-and-refill on the same edge
    out_ready = 4'b1011;
    drive(1'b1, 1'b0, 2'd2, 8'h11);
    #1 check("bp_ready_empty", 32'(in_ready), 32'h1);
    @(negedge clk);
    check("bp_valid1", 32'(out_valid), 32'h4);
    check("bp_data1",  32'(lane(2)),   32'h11);
    in_data = 8'h22;
    #1 check("bp_ready_stall", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("bp_held", 32'(lane(2)),   32'h11);
    check("bp_valid_held", 32'(out_valid), 32'h4);
    out_ready = 4'b1111;
    #1 check("bp_ready_refill", 32'(in_ready), 32'h1);
    @(negedge clk);
    check("bp_valid2", 32'(out_valid), 32'h4);
    check("bp_data2",  32'(lane(2)),   32'h22);
    drive(1'b0, 1'b0, 2'd2, 8'h00);
    @(negedge clk);
    check("bp_drained", 32'(out_valid), 32'h0);

    // Round-robin: six beats land on lanes 0,1,2,3,0,1
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 2'd0, 8'(i + 1));
      @(negedge clk);
      check("rr_valid", 32'(out_valid),   32'(4'b0001 << (i % 4)));
      check("rr_data",  32'(lane(i % 4)), 32'(i + 1));
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    check("rr_ptr_end", 32'(rr_ptr), 32'h2);

    // Independent lanes: lane 0 stalled at 0x55, lanes 1..3 keep flowing
    out_ready = 4'b1110;
    drive(1'b1, 1'b0, 2'd0, 8'h55);
    @(negedge clk);
    for (int k = 1; k < 4; k++) begin
      drive(1'b1, 1'b0, 2'(k), 8'(8'h60 + k));
      #1 check("ind_ready", 32'(in_ready), 32'h1);
      @(negedge clk);
      check("ind_valid", 32'(out_valid), 32'(4'b0001 | (4'b0001 << k)));
      check("ind_data",  32'(lane(k)),   32'(8'h60 + k));
      check("ind_lane0", 32'(lane(0)),   32'h55);
    end
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    #1 check("ind_ready_idle", 32'(in_ready), 32'h0);
    @(negedge clk);
    check("ind_only_lane0", 32'(out_valid), 32'h1);
    check("ind_lane0_end",  32'(lane(0)),   32'h55);
    check("ind_rr_hold",    32'(rr_ptr),    32'h2);

    // Build lanes 1 and 3 full with rr_ptr=3, then reset between edges
    out_ready = 4'b0001;
    @(negedge clk);
    check("pre_rst_empty", 32'(out_valid), 32'h0);
    out_ready = 4'b0100;
    drive(1'b1, 1'b0, 2'd1, 8'h81);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'd0, 8'h82);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'd3, 8'h83);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    check("pre_rst_valid", 32'(out_valid), 32'hA);
    check("pre_rst_rr",    32'(rr_ptr),    32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_rr",    32'(rr_ptr),    32'h0);
    check("mid_rst_data",  out_data,       32'h0);
    check("mid_rst_ready", 32'(in_ready),  32'h0);
    #1 rst_n = 1'b1;

    // Mode mix, starting on the first edge after reset release
    out_ready = 4'b1111;
    drive(1'b1, 1'b1, 2'd0, 8'h91);
    @(negedge clk);
    check("mix_valid0", 32'(out_valid), 32'h1);
    check("mix_data0",  32'(lane(0)),   32'h91);
    check("mix_rr1",    32'(rr_ptr),    32'h1);
    in_data = 8'h92;
    @(negedge clk);
    check("mix_data1", 32'(lane(1)),  32'h92);
    check("mix_rr2",   32'(rr_ptr),   32'h2);
    drive(1'b1, 1'b0, 2'd3, 8'h93);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0, 8'h00);
    check("mix_valid3", 32'(out_valid), 32'h8);
    check("mix_data3",  32'(lane(3)),   32'h93);
    check("mix_rr_hold", 32'(rr_ptr),   32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
